// File: rtl/hsid_pkg.sv
// Shared HSID widths, sizes and the vector streamer state encoding.
// Imported by the streamer and the downstream MSE datapath.
package hsid_pkg;

   localparam int HSID_WORD_WIDTH      = 64;
   localparam int HSID_DATA_WIDTH      = 16;
   localparam int HSID_MAX_HSP_BANDS   = 32;
   localparam int HSID_MAX_HSP_LIBRARY = 8;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN,
      DONE
   } hsid_streamer_state_t;

endpackage

// File: rtl/hsid_vctr_streamer.sv
// Streams one pixel vector against every library vector as
// word-pair beats for the MSE register stage.
module hsid_vctr_streamer
   import hsid_pkg::*;
#(
   parameter int WORD_WIDTH       = HSID_WORD_WIDTH,
   parameter int DATA_WIDTH       = HSID_DATA_WIDTH,
   parameter int HSI_BANDS        = HSID_MAX_HSP_BANDS,
   parameter int HSI_LIBRARY_SIZE = HSID_MAX_HSP_LIBRARY,
   localparam int ELEMENTS = HSI_BANDS / (WORD_WIDTH / DATA_WIDTH),
   localparam int EADDR    = $clog2(ELEMENTS),
   localparam int LADDR    = $clog2(HSI_LIBRARY_SIZE),
   localparam int LIB_ADDR = $clog2(ELEMENTS * HSI_LIBRARY_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  clear,
   input  logic [EADDR:0]        hsp_bands_packed,
   input  logic [LADDR:0]        hsp_library_size,
   output logic                  px_rd_en,
   output logic [EADDR-1:0]      px_rd_addr,
   input  logic [WORD_WIDTH-1:0] px_rd_data,
   output logic                  lib_rd_en,
   output logic [LIB_ADDR-1:0]   lib_rd_addr,
   input  logic [WORD_WIDTH-1:0] lib_rd_data,
   output logic                  element_start,
   output logic                  element_last,
   output logic                  element_valid,
   output logic [WORD_WIDTH-1:0] element_a,
   output logic [WORD_WIDTH-1:0] element_b,
   output logic [LADDR-1:0]      vctr_ref,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam logic [EADDR:0] BANDS_MAX = (EADDR+1)'(ELEMENTS);
   localparam logic [LADDR:0] LIB_MAX   = (LADDR+1)'(HSI_LIBRARY_SIZE);

   hsid_streamer_state_t state_q, state_d;

   logic [EADDR:0]     bands_q;
   logic [LADDR:0]     lib_q;
   logic [EADDR-1:0]   word_q;
   logic [LADDR-1:0]   ref_q;

   logic               v1_q;
   logic               s1_q;
   logic               l1_q;
   logic [LADDR-1:0]   r1_q;

   logic               cfg_ok;
   logic               accept;
   logic               rd;
   logic               word_last;
   logic               ref_last;

   assign cfg_ok = (hsp_bands_packed != '0)
                && (hsp_bands_packed <= BANDS_MAX)
                && (hsp_library_size != '0)
                && (hsp_library_size <= LIB_MAX);

   assign accept = (state_q == IDLE) && start
                && !clear && cfg_ok;

   assign rd        = (state_q == STREAM);
   assign word_last = ({1'b0, word_q} == bands_q - 1'b1);
   assign ref_last  = ({1'b0, ref_q} == lib_q - 1'b1);

   assign px_rd_en    = rd;
   assign lib_rd_en   = rd;
   assign px_rd_addr  = word_q;
   assign lib_rd_addr = LIB_ADDR'(ref_q) * LIB_ADDR'(ELEMENTS)
                      + LIB_ADDR'(word_q);

   assign busy = (state_q == STREAM) || (state_q == DRAIN);
   assign done = (state_q == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // DRAIN ends once the final beat sits on the outputs
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (start && cfg_ok) state_d = STREAM;
            STREAM:  if (word_last && ref_last) state_d = DRAIN;
            DRAIN:   if (!v1_q && element_valid) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bands_q <= '0;
         lib_q   <= '0;
         word_q  <= '0;
         ref_q   <= '0;
      end else if (clear) begin
         word_q  <= '0;
         ref_q   <= '0;
      end else if (accept) begin
         bands_q <= hsp_bands_packed;
         lib_q   <= hsp_library_size;
         word_q  <= '0;
         ref_q   <= '0;
      end else if (rd) begin
         if (word_last) begin
            word_q <= '0;
            if (!ref_last) ref_q <= ref_q + 1'b1;
         end else begin
            word_q <= word_q + 1'b1;
         end
      end
   end

   // Stage 1 tracks framing while the memories return data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0;
         s1_q <= 1'b0;
         l1_q <= 1'b0;
         r1_q <= '0;
      end else begin
         v1_q <= rd && !clear;
         s1_q <= rd && (word_q == '0);
         l1_q <= rd && word_last;
         r1_q <= ref_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         element_valid <= 1'b0;
         element_start <= 1'b0;
         element_last  <= 1'b0;
         element_a     <= '0;
         element_b     <= '0;
         vctr_ref      <= '0;
      end else if (clear) begin
         element_valid <= 1'b0;
         element_start <= 1'b0;
         element_last  <= 1'b0;
      end else begin
         element_valid <= v1_q;
         element_start <= v1_q && s1_q;
         element_last  <= v1_q && l1_q;
         if (v1_q) begin
            element_a <= px_rd_data;
            element_b <= lib_rd_data;
            vctr_ref  <= r1_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         error <= 1'b0;
      end else begin
         error <= (state_q == IDLE) && start
               && !clear && !cfg_ok;
      end
   end

endmodule
